// File: rtl/inst_fetch_bridge.sv
// ============================================================================
// Module   : inst_fetch_bridge
// Purpose  : Uncached instruction fetch responder. Merges the PC-stage index
//            with the late MMU tag and returns one 4-word line via a burst read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_bridge #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [INDEX_W-1:0] inst_index,
  input  logic [31:0]        inst_wdata,
  output logic               inst_index_ok,
  input  logic [TAG_W-1:0]   inst_tag,
  output logic [127:0]       inst_rdata,
  output logic               inst_data_ok,
  input  logic               flush,
  output logic               mem_arvalid,
  output logic [31:0]        mem_araddr,
  output logic [7:0]         mem_arlen,
  input  logic               mem_arready,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rlast,
  output logic               mem_rready
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TAG  = 3'd1;
  localparam logic [2:0] ST_AR   = 3'd2;
  localparam logic [2:0] ST_R    = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  logic [2:0]         state;
  logic [INDEX_W-1:0] index_q;
  logic [31:0]        addr_q;
  logic [1:0]         beat_cnt;
  logic               cancel;
  logic [127:0]       line_buf;

  // Write-side fields are part of the sram-like interface but have no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_size, inst_wdata, mem_rlast};

  assign inst_index_ok = !rst && (state == ST_IDLE) && inst_req && !flush;
  assign mem_arvalid   = !rst && (state == ST_AR);
  assign mem_arlen     = mem_arvalid ? 8'd3 : 8'd0;
  assign mem_araddr    = addr_q;
  assign mem_rready    = !rst && (state == ST_R);
  assign inst_data_ok  = !rst && (state == ST_RESP) && !flush;
  assign inst_rdata    = line_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      index_q  <= '0;
      addr_q   <= '0;
      beat_cnt <= 2'd0;
      cancel   <= 1'b0;
      line_buf <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst_req && !flush) begin
            index_q <= inst_index;
            state   <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            addr_q <= {inst_tag, index_q, 4'b0000};
            state  <= ST_AR;
          end
        end
        ST_AR: begin
          // The address request cannot be withdrawn, so a flush only marks it.
          if (flush) cancel <= 1'b1;
          if (mem_arready) begin
            beat_cnt <= 2'd0;
            state    <= ST_R;
          end
        end
        ST_R: begin
          if (mem_rvalid) begin
            line_buf[{beat_cnt, 5'b00000} +: 32] <= mem_rdata;
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              state  <= (cancel || flush) ? ST_IDLE : ST_RESP;
              cancel <= 1'b0;
            end else if (flush) begin
              cancel <= 1'b1;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The beat counter owns burst termination; rlast must agree with it.
  a_rlast_matches_count: assert property (@(posedge clk) disable iff (rst)
    (state == ST_R && mem_rvalid) |-> (mem_rlast == (beat_cnt == 2'd3)));

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_bridge.sv
// ============================================================================
// Module   : tb_inst_fetch_bridge
// Purpose  : Scoreboard bench for inst_fetch_bridge with a burst memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inst_req = 1'b0;
  logic         inst_wr = 1'b0;
  logic [1:0]   inst_size = 2'b11;
  logic [7:0]   inst_index = 8'h00;
  logic [31:0]  inst_wdata = 32'h0;
  logic         inst_index_ok;
  logic [19:0]  inst_tag = 20'h0;
  logic [127:0] inst_rdata;
  logic         inst_data_ok;
  logic         flush = 1'b0;
  logic         mem_arvalid;
  logic [31:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic         mem_arready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         mem_rlast;
  logic         mem_rready;

  inst_fetch_bridge #(.INDEX_W(8), .TAG_W(20)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_index(inst_index), .inst_wdata(inst_wdata), .inst_index_ok(inst_index_ok),
    .inst_tag(inst_tag), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .flush(flush),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {inst_index_ok, mem_arvalid, mem_araddr, mem_arlen, mem_rready, inst_data_ok}, '0);
    check({tag, "_rdata"}, inst_rdata, '0);
  endtask

  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_line_q[$];

  // Memory model configuration and progress, shared with the driver.
  int          ar_wait = 0;
  int          r_gap = 0;
  logic [31:0] mem_base = 32'h0;
  int          mst = 0;
  int          beat = 0;
  int          wcnt = 0;
  int          gcnt = 0;
  int          done_cnt = 0;
  int          dok_cnt = 0;
  logic [31:0] hold_addr = 32'h0;

  initial begin
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mst = 0;
      end else begin
        if (mst == 0 && mem_arvalid) begin
          if (exp_addr_q.size() == 0) check("ar_unexpected", 1, 0);
          else check("araddr", mem_araddr, exp_addr_q.pop_front());
          check("arlen", mem_arlen, 8'd3);
          hold_addr = mem_araddr; wcnt = ar_wait; beat = 0; mst = 1;
        end else if (mst == 1 && mem_arready) begin
          mem_arready = 1'b0; gcnt = r_gap; mst = 2;
        end else if (mst == 1) begin
          check("ar_hold", {mem_arvalid, mem_araddr}, {1'b1, hold_addr});
        end
        if (mst == 1) begin
          if (wcnt == 0) mem_arready = 1'b1;
          else wcnt--;
        end
        if (mst == 2) begin
          if (mem_rvalid) begin
            mem_rvalid = 1'b0; mem_rlast = 1'b0; beat++; gcnt = r_gap;
            if (beat == 4) begin mst = 0; done_cnt++; end
          end
          if (mst == 2) begin
            if (gcnt == 0) begin
              check("rready", mem_rready, 1);
              mem_rvalid = 1'b1;
              mem_rdata  = mem_base + 32'(beat);
              mem_rlast  = (beat == 3);
            end else begin
              gcnt--;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (inst_data_ok) begin
        dok_cnt++;
        if (exp_line_q.size() == 0) check("data_ok_unexpected", 1, 0);
        else check("rdata", inst_rdata, exp_line_q.pop_front());
      end
    end
  end

  // mode: 0 normal, 1 flush in TAG then re-accept, 2 flush after beat 1,
  //       3 flush in RESP, 5 reset during R
  task automatic fetch(input logic [7:0] idx, input logic [19:0] tag, input logic [31:0] base,
                       input int aw, input int rg, input int mode, input bit hold_req,
                       input bit pre_flush);
    int  d0, b0;
    bit  fl, done;
    ar_wait = aw; r_gap = rg; mem_base = base; fl = 0; done = 0;
    @(posedge clk); #1;
    flush = pre_flush; inst_req = 1'b1; inst_index = idx;
    if (pre_flush) begin
      @(negedge clk); #1;
      check("flush_req_index_ok", inst_index_ok, 0);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); #1;
      check("index_ok", inst_index_ok, 1);
      @(posedge clk); #1;
      inst_tag = tag; inst_req = hold_req;
      if (mode == 1 && pass == 0) begin
        flush = 1'b1;
        @(negedge clk); #1;
        check("tag_flush_arvalid", mem_arvalid, 0);
        @(posedge clk); #1;
        flush = 1'b0; inst_req = 1'b1;
      end else begin
        break;
      end
    end
    exp_addr_q.push_back({tag, idx, 4'h0});
    if (mode <= 1) exp_line_q.push_back({base + 32'd3, base + 32'd2, base + 32'd1, base});
    d0 = dok_cnt; b0 = done_cnt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (i == 0) check("tag_arvalid", mem_arvalid, 0);
      if (hold_req) check("busy_index_ok", inst_index_ok, 0);
      if (mode == 3 && i == 6) check("resp_flush_data_ok", inst_data_ok, 0);
      if (mode <= 1) begin
        if (dok_cnt != d0) begin
          if (aw == 0 && rg == 0) check("latency", i, 6);
          done = 1;
        end
      end else if (mode == 5) begin
        if (mst == 2 && beat == 1) begin
          @(posedge clk); #1; rst = 1'b1;
          @(posedge clk); #1; rst = 1'b0;
          @(negedge clk); #1;
          check_idle_outputs("rst_mid_burst");
          done = 1;
        end
      end else if (done_cnt != b0) begin
        done = 1;
      end
      if (done) break;
      @(posedge clk); #1;
      flush = 1'b0; inst_tag = 20'($urandom);
      if (mode == 2 && mst == 2 && beat == 2 && !fl) begin flush = 1'b1; fl = 1; end
      if (mode == 3 && i + 1 == 6) flush = 1'b1;
    end
    if (!done) check("fetch_timeout", 0, 1);
    @(posedge clk); #1;
    flush = 1'b0; inst_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_idle_outputs("post_reset");

    fetch(8'h0F, 20'hBFC00, 32'h1111_0000, 0, 0, 0, 0, 0);
    fetch(8'h21, 20'h12345, 32'hA000_0010, 3, 2, 0, 1, 0);
    fetch(8'h33, 20'h00042, 32'h2222_0000, 0, 0, 1, 0, 0);
    fetch(8'h44, 20'h55555, 32'h3333_0000, 0, 1, 2, 0, 0);
    fetch(8'h45, 20'h55555, 32'h3434_0000, 0, 0, 0, 0, 0);
    fetch(8'h50, 20'h0ABCD, 32'h4444_0000, 0, 0, 3, 0, 0);
    fetch(8'h51, 20'h0ABCD, 32'h4545_0000, 1, 1, 0, 0, 0);
    fetch(8'h60, 20'hFFFFF, 32'h5555_0000, 0, 1, 5, 0, 0);
    fetch(8'h61, 20'h00001, 32'h5656_0000, 0, 0, 0, 0, 0);
    fetch(8'hFF, 20'h7F00F, 32'h6666_0000, 0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      fetch(8'($urandom), 20'($urandom), $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), 0, 0, 0);
    end

    repeat (4) @(posedge clk);
    check("addr_queue_drained", 128'(exp_addr_q.size()), 0);
    check("line_queue_drained", 128'(exp_line_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
